// File: rtl/alu_decode_stage.sv
// Decode/issue stage for the integer ALU: RV32I OP/OP-IMM -> one-hot select plus operands.
// One cycle latency; single-entry output register with valid/ready; illegal words are consumed and counted.
module alu_decode_stage #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_rs1_val,
  input  logic [31:0]          in_rs2_val,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          reg_op1,
  output logic [31:0]          reg_op2,
  output logic                 instr_add,
  output logic                 instr_sub,
  output logic                 instr_and,
  output logic                 instr_or,
  output logic                 instr_xor,
  output logic                 instr_sll,
  output logic                 instr_srl,
  output logic                 instr_sra,
  output logic [4:0]           out_rd,
  output logic                 illegal,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // Select bit order: {sra, srl, sll, xor, or, and, sub, add}
  localparam logic [7:0] SEL_ADD = 8'h01;
  localparam logic [7:0] SEL_SUB = 8'h02;
  localparam logic [7:0] SEL_AND = 8'h04;
  localparam logic [7:0] SEL_OR  = 8'h08;
  localparam logic [7:0] SEL_XOR = 8'h10;
  localparam logic [7:0] SEL_SLL = 8'h20;
  localparam logic [7:0] SEL_SRL = 8'h40;
  localparam logic [7:0] SEL_SRA = 8'h80;

  logic                 r_out_valid;
  logic [31:0]          r_op1;
  logic [31:0]          r_op2;
  logic [7:0]           r_sel;
  logic [4:0]           r_rd;
  logic                 r_illegal;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic        w_accept;
  logic        w_transfer;
  logic        w_is_op;
  logic        w_is_imm;
  logic        w_f7_zero;
  logic        w_f7_alt;
  logic        w_is_shift;
  logic [2:0]  w_f3;
  logic        w_legal;
  logic [7:0]  w_sel;
  logic [31:0] w_op2;
  logic        w_unused_rs1_field;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_transfer = r_out_valid && out_ready;

  assign w_is_op    = (in_instr[6:0] == OPC_OP);
  assign w_is_imm   = (in_instr[6:0] == OPC_OP_IMM);
  assign w_f3       = in_instr[14:12];
  assign w_f7_zero  = (in_instr[31:25] == 7'b0000000);
  assign w_f7_alt   = (in_instr[31:25] == 7'b0100000);
  assign w_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);
  assign w_unused_rs1_field = ^in_instr[19:15];

  always_comb begin
    w_sel   = '0;
    w_legal = 1'b0;
    if (w_is_op || w_is_imm) begin
      case (w_f3)
        3'b000: begin
          if (w_is_imm || w_f7_zero) begin
            w_sel = SEL_ADD; w_legal = 1'b1;
          end else if (w_f7_alt) begin
            w_sel = SEL_SUB; w_legal = 1'b1;
          end
        end
        3'b100: if (w_is_imm || w_f7_zero) begin w_sel = SEL_XOR; w_legal = 1'b1; end
        3'b110: if (w_is_imm || w_f7_zero) begin w_sel = SEL_OR;  w_legal = 1'b1; end
        3'b111: if (w_is_imm || w_f7_zero) begin w_sel = SEL_AND; w_legal = 1'b1; end
        3'b001: if (w_f7_zero) begin w_sel = SEL_SLL; w_legal = 1'b1; end
        3'b101: begin
          if (w_f7_zero) begin
            w_sel = SEL_SRL; w_legal = 1'b1;
          end else if (w_f7_alt) begin
            w_sel = SEL_SRA; w_legal = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Immediate shifts take only the 5-bit shamt; the funct7 bits are not part of the operand.
  assign w_op2 = w_is_op    ? in_rs2_val :
                 w_is_shift ? {27'b0, in_instr[24:20]} :
                              {{20{in_instr[31]}}, in_instr[31:20]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_sel       <= '0;
      r_rd        <= '0;
      r_illegal   <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_illegal <= 1'b0;
      if (w_accept) begin
        if (w_legal) begin
          r_out_valid <= 1'b1;
          r_op1       <= in_rs1_val;
          r_op2       <= w_op2;
          r_sel       <= w_sel;
          r_rd        <= in_instr[11:7];
        end else begin
          r_out_valid <= 1'b0;
          r_sel       <= '0;
          r_illegal   <= 1'b1;
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
      end else if (w_transfer) begin
        r_out_valid <= 1'b0;
        r_sel       <= '0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign reg_op1   = r_op1;
  assign reg_op2   = r_op2;
  assign out_rd    = r_rd;
  assign illegal   = r_illegal;
  assign err_count = r_err_cnt;
  assign {instr_sra, instr_srl, instr_sll, instr_xor,
          instr_or, instr_and, instr_sub, instr_add} = r_sel;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed self-checking bench for alu_decode_stage.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] reg_op1;
  logic [31:0] reg_op2;
  logic        instr_add, instr_sub, instr_and, instr_or;
  logic        instr_xor, instr_sll, instr_srl, instr_sra;
  logic [4:0]  out_rd;
  logic        illegal;
  logic [7:0]  err_count;
  logic [7:0]  flags;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_decode_stage #(.ERR_CNT_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg_op1(reg_op1), .reg_op2(reg_op2),
    .instr_add(instr_add), .instr_sub(instr_sub), .instr_and(instr_and), .instr_or(instr_or),
    .instr_xor(instr_xor), .instr_sll(instr_sll), .instr_srl(instr_srl), .instr_sra(instr_sra),
    .out_rd(out_rd), .illegal(illegal), .err_count(err_count)
  );

  assign flags = {instr_sra, instr_srl, instr_sll, instr_xor, instr_or, instr_and, instr_sub, instr_add};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream table: {funct7, funct3} for add, sub, and, or, xor, sll, srl, sra
  logic [6:0] s_f7 [8] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20};
  logic [2:0] s_f3 [8] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b100, 3'b001, 3'b101, 3'b101};
  logic [31:0] ill_tab [4] = '{32'h0020A1B3, 32'h0020B1B3, 32'h802081B3, 32'h00000003};

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_instr = '0;
    in_rs1_val = '0; in_rs2_val = '0; out_ready = 1'b1;
    repeat (3) step();
    resetn = 1'b1;
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", flags, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_in_ready", in_ready, 1);

    // ADD x3, x1, x2
    in_valid = 1'b1; in_instr = 32'h002081B3; in_rs1_val = 5; in_rs2_val = 3;
    step();
    chk("add_valid", out_valid, 1);
    chk("add_flags", flags, 8'h01);
    chk("add_op1", reg_op1, 5);
    chk("add_op2", reg_op2, 3);
    chk("add_rd", out_rd, 3);

    // SUB back-to-back
    in_instr = 32'h402081B3; in_rs1_val = 9; in_rs2_val = 4;
    step();
    chk("sub_valid", out_valid, 1);
    chk("sub_flags", flags, 8'h02);
    chk("sub_op1", reg_op1, 9);
    chk("sub_op2", reg_op2, 4);

    // ADDI x1, x?, -1
    in_instr = 32'hFFF00093; in_rs1_val = 7; in_rs2_val = 32'h12345678;
    step();
    chk("addi_flags", flags, 8'h01);
    chk("addi_op1", reg_op1, 7);
    chk("addi_op2", reg_op2, 32'hFFFFFFFF);
    chk("addi_rd", out_rd, 1);

    // SRAI x5, x?, 4
    in_instr = 32'h40435293; in_rs1_val = 32'hF0000000;
    step();
    chk("srai_flags", flags, 8'h80);
    chk("srai_op1", reg_op1, 32'hF0000000);
    chk("srai_op2", reg_op2, 4);
    chk("srai_rd", out_rd, 5);

    in_valid = 1'b0;
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_flags", flags, 0);

    // Backpressure: hold ADD, present SUB
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_rs1_val = 5; in_rs2_val = 3;
    step();
    in_instr = 32'h402081B3; in_rs1_val = 1; in_rs2_val = 2;
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_flags", flags, 8'h01);
      chk("bp_op1", reg_op1, 5);
      chk("bp_op2", reg_op2, 3);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    step();
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_flags", flags, 8'h02);
    chk("bp_next_op1", reg_op1, 1);
    chk("bp_next_op2", reg_op2, 2);
    in_valid = 1'b0;
    step();
    chk("bp_drain_valid", out_valid, 0);

    // SLT is illegal
    in_valid = 1'b1; in_instr = 32'h0020A1B3;
    step();
    in_valid = 1'b0;
    chk("slt_illegal", illegal, 1);
    chk("slt_valid", out_valid, 0);
    chk("slt_err_count", err_count, 1);
    step();
    chk("slt_pulse_end", illegal, 0);
    chk("slt_err_hold", err_count, 1);

    // Illegal accepted while the output register transfers
    in_valid = 1'b1; in_instr = 32'h002081B3; in_rs1_val = 5; in_rs2_val = 3;
    step();
    chk("pre_ill_valid", out_valid, 1);
    in_instr = 32'h802081B3;
    step();
    chk("xfer_ill_valid", out_valid, 0);
    chk("xfer_ill_flags", flags, 0);
    chk("xfer_ill_pulse", illegal, 1);
    chk("xfer_ill_err", err_count, 2);

    // 298 more illegal words: 300 total saturates at 255
    for (int k = 0; k < 298; k++) begin
      in_instr = ill_tab[k % 4];
      step();
    end
    in_valid = 1'b0;
    chk("sat_illegal", illegal, 1);
    chk("sat_valid", out_valid, 0);
    chk("sat_err_count", err_count, 255);
    step();
    chk("sat_err_hold", err_count, 255);

    // Stream 16 legal OP instructions through all eight selects
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [4:0] rd;
      rd = 5'(i + 1);
      in_instr = {s_f7[i % 8], 5'd2, 5'd1, s_f3[i % 8], rd, 7'b0110011};
      in_rs1_val = 32'h100 + 32'(i);
      in_rs2_val = 32'hA000 + 32'(i);
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_flags", flags, 32'(8'h01 << (i % 8)));
      chk("stream_op1", reg_op1, 32'h100 + 32'(i));
      chk("stream_op2", reg_op2, 32'hA000 + 32'(i));
      chk("stream_rd", out_rd, 32'(i + 1));
    end
    in_valid = 1'b0;
    step();
    chk("stream_end_valid", out_valid, 0);

    // Asynchronous reset while an ADD is held
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_rs1_val = 5; in_rs2_val = 3;
    step();
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_flags", flags, 0);
    chk("arst_op1", reg_op1, 0);
    chk("arst_op2", reg_op2, 0);
    chk("arst_rd", out_rd, 0);
    chk("arst_illegal", illegal, 0);
    chk("arst_err_count", err_count, 0);
    step();
    resetn = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
